// File: rtl/systolic_tile_sequencer_if.sv
// ----------------------------------------------------------------------------
// systolic_tile_sequencer_if
//   Groups the job-control and phase-status signals of the tile sequencer into
//   one bundle.
//   master : the job requester. It drives start, num_tiles, abort and
//            store_ready, and observes the status outputs.
//   slave  : the sequencer itself. It drives global_state, cycle, tile_idx,
//            the per-phase enables, busy, done and aborted.
// ----------------------------------------------------------------------------
interface systolic_tile_sequencer_if #(
  parameter int TILE_W  = 8,
  parameter int CYCLE_W = 5
);
  logic                start;
  logic [TILE_W-1:0]   num_tiles;
  logic                abort;
  logic                store_ready;
  logic [1:0]          global_state;
  logic [CYCLE_W-1:0]  cycle;
  logic [TILE_W-1:0]   tile_idx;
  logic                load_en;
  logic                mac_en;
  logic                store_valid;
  logic                busy;
  logic                done;
  logic                aborted;

  modport master (
    output start, num_tiles, abort, store_ready,
    input  global_state, cycle, tile_idx, load_en, mac_en, store_valid,
           busy, done, aborted
  );

  modport slave (
    input  start, num_tiles, abort, store_ready,
    output global_state, cycle, tile_idx, load_en, mac_en, store_valid,
           busy, done, aborted
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// ----------------------------------------------------------------------------
// systolic_tile_sequencer
//   Runs a job of num_tiles tiles back to back. Each tile goes through three
//   phases in order: LOAD_X, then MAC, then STORE. The STORE phase is stalled
//   by store_ready. The block sits above the PE array and drives the
//   per-phase enables and the in-tile cycle index.
// Ports
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : systolic_tile_sequencer_if.slave
//            inputs  : start, num_tiles, abort, store_ready
//            outputs : global_state (0 IDLE, 1 LOAD_X, 2 MAC, 3 STORE),
//                      cycle, tile_idx, load_en, mac_en, store_valid,
//                      busy, done (pulse), aborted (pulse)
// ----------------------------------------------------------------------------
module systolic_tile_sequencer #(
  parameter int ROWS        = 2,
  parameter int COLS        = 4,
  parameter int STORE_BEATS = 2,
  parameter int CYCLE_W     = 5,
  parameter int TILE_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_tile_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOADX = 2'd1,
    ST_MAC   = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  // The cycle index is 1-based inside a tile. Each constant below is the
  // index of the last cycle of a phase.
  localparam logic [CYCLE_W-1:0] LOAD_END_C  = CYCLE_W'(ROWS);
  localparam logic [CYCLE_W-1:0] MAC_END_C   = CYCLE_W'(ROWS + COLS);
  localparam logic [CYCLE_W-1:0] STORE_END_C = CYCLE_W'(ROWS + COLS + STORE_BEATS);
  localparam logic [CYCLE_W-1:0] CYCLE_ONE_C = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] CYCLE_ZERO_C = CYCLE_W'(0);
  localparam logic [TILE_W-1:0]  TILE_ONE_C  = TILE_W'(1);
  localparam logic [TILE_W-1:0]  TILE_ZERO_C = TILE_W'(0);

  state_t              state_r,   state_nxt_s;
  logic [CYCLE_W-1:0]  cycle_r,   cycle_nxt_s;
  logic [TILE_W-1:0]   tile_r,    tile_nxt_s;
  logic [TILE_W-1:0]   ntiles_r,  ntiles_nxt_s;
  logic                done_r,    done_nxt_s;
  logic                aborted_r, aborted_nxt_s;
  logic                beat_s;
  logic                last_tile_s;

  assign beat_s      = (state_r == ST_STORE) && bus.store_ready;
  assign last_tile_s = (tile_r == (ntiles_r - TILE_ONE_C));

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cycle_r   <= CYCLE_ZERO_C;
      tile_r    <= TILE_ZERO_C;
      ntiles_r  <= TILE_ZERO_C;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cycle_r   <= cycle_nxt_s;
      tile_r    <= tile_nxt_s;
      ntiles_r  <= ntiles_nxt_s;
      done_r    <= done_nxt_s;
      aborted_r <= aborted_nxt_s;
    end
  end

  // Next-state, counter and pulse logic. Abort takes priority over every phase
  // transition, including the final store beat.
  always_comb begin
    state_nxt_s   = state_r;
    cycle_nxt_s   = cycle_r;
    tile_nxt_s    = tile_r;
    ntiles_nxt_s  = ntiles_r;
    done_nxt_s    = 1'b0;
    aborted_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cycle_nxt_s = CYCLE_ZERO_C;
        tile_nxt_s  = TILE_ZERO_C;
        if (bus.start && !bus.abort) begin
          if (bus.num_tiles != TILE_ZERO_C) begin
            state_nxt_s  = ST_LOADX;
            cycle_nxt_s  = CYCLE_ONE_C;
            ntiles_nxt_s = bus.num_tiles;
          end else begin
            // An empty job completes at once.
            done_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_LOADX: begin
        if (bus.abort) begin
          state_nxt_s   = ST_IDLE;
          cycle_nxt_s   = CYCLE_ZERO_C;
          tile_nxt_s    = TILE_ZERO_C;
          aborted_nxt_s = 1'b1;
        end else begin
          cycle_nxt_s = cycle_r + CYCLE_ONE_C;
          if (cycle_r == LOAD_END_C) begin
            state_nxt_s = ST_MAC;
          end else begin
            state_nxt_s = ST_LOADX;
          end
        end
      end

      ST_MAC: begin
        if (bus.abort) begin
          state_nxt_s   = ST_IDLE;
          cycle_nxt_s   = CYCLE_ZERO_C;
          tile_nxt_s    = TILE_ZERO_C;
          aborted_nxt_s = 1'b1;
        end else begin
          cycle_nxt_s = cycle_r + CYCLE_ONE_C;
          if (cycle_r == MAC_END_C) begin
            state_nxt_s = ST_STORE;
          end else begin
            state_nxt_s = ST_MAC;
          end
        end
      end

      ST_STORE: begin
        if (bus.abort) begin
          state_nxt_s   = ST_IDLE;
          cycle_nxt_s   = CYCLE_ZERO_C;
          tile_nxt_s    = TILE_ZERO_C;
          aborted_nxt_s = 1'b1;
        end else if (beat_s && (cycle_r == STORE_END_C)) begin
          if (last_tile_s) begin
            state_nxt_s = ST_IDLE;
            cycle_nxt_s = CYCLE_ZERO_C;
            tile_nxt_s  = TILE_ZERO_C;
            done_nxt_s  = 1'b1;
          end else begin
            // The next tile starts LOAD_X right away, with no idle cycle.
            state_nxt_s = ST_LOADX;
            cycle_nxt_s = CYCLE_ONE_C;
            tile_nxt_s  = tile_r + TILE_ONE_C;
          end
        end else if (beat_s) begin
          cycle_nxt_s = cycle_r + CYCLE_ONE_C;
        end else begin
          // Downstream is stalling, so hold the current beat.
          cycle_nxt_s = cycle_r;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        cycle_nxt_s = CYCLE_ZERO_C;
        tile_nxt_s  = TILE_ZERO_C;
      end
    endcase
  end

  assign bus.global_state = state_r;
  assign bus.cycle        = cycle_r;
  assign bus.tile_idx     = tile_r;
  assign bus.load_en      = (state_r == ST_LOADX);
  assign bus.mac_en       = (state_r == ST_MAC);
  assign bus.store_valid  = (state_r == ST_STORE);
  assign bus.busy         = (state_r != ST_IDLE);
  assign bus.done         = done_r;
  assign bus.aborted      = aborted_r;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_systolic_tile_sequencer
//   Directed bench for systolic_tile_sequencer with ROWS=2, COLS=4 and
//   STORE_BEATS=2. The bench builds the expected per-cycle trace of each job
//   and pushes it onto a queue together with the inputs to drive in that
//   cycle. On each falling edge it pops one entry, compares the outputs and
//   then applies that entry's inputs.
// ----------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

  localparam int ROWS = 2, COLS = 4, SB = 2, CW = 5, TW = 8;
  localparam int TILE_LEN = ROWS + COLS + SB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_tile_sequencer_if #(.TILE_W(TW), .CYCLE_W(CW)) bus ();

  systolic_tile_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .STORE_BEATS(SB), .CYCLE_W(CW), .TILE_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit chk;
    int st, cyc, tile, dn, ab;
    bit start, abort, ready, rs;
    int n;
  } rec_t;

  rec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int st, input int cyc, input int tile, input int dn,
                      input int ab, input bit start, input int n, input bit abort,
                      input bit ready, input bit rs);
    rec_t r;
    r.chk = 1'b1; r.st = st; r.cyc = cyc; r.tile = tile; r.dn = dn; r.ab = ab;
    r.start = start; r.n = n; r.abort = abort; r.ready = ready; r.rs = rs;
    sb_q.push_back(r);
  endtask

  function automatic int phase_of(input int c);
    if (c <= ROWS)             return 1;
    else if (c <= ROWS + COLS) return 2;
    else                       return 3;
  endfunction

  // Pushes the trace of one job. A tile index of -1 disables that event.
  //   stall_t   : stall STORE for 3 clocks at the first beat of this tile
  //   ev_t/ev_c : abort (ev_rst=0) or rst (ev_rst=1) at this tile/cycle
  //   bs_t      : pulse start with a new num_tiles at cycle 3 of this tile
  task automatic job(input int n, input int stall_t, input int ev_t, input int ev_c,
                     input bit ev_rst, input int bs_t);
    push(0, 0, 0, 0, 0, 1'b1, n, 1'b0, 1'b1, 1'b0);
    for (int t = 0; t < n; t++) begin
      for (int c = 1; c <= TILE_LEN; c++) begin
        if (t == stall_t && c == ROWS + COLS + 1) begin
          for (int k = 0; k < 3; k++) push(3, c, t, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        if (t == ev_t && c == ev_c) begin
          push(phase_of(c), c, t, 0, 0, 1'b0, 0, !ev_rst, 1'b1, ev_rst);
          push(0, 0, 0, 0, ev_rst ? 0 : 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
          push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
          return;
        end
        push(phase_of(c), c, t, 0, 0, (t == bs_t && c == 3), (t == bs_t && c == 3) ? 5 : 0,
             1'b0, 1'b1, 1'b0);
      end
    end
    push(0, 0, 0, 1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    rec_t r;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      r = sb_q.pop_front();
      if (r.chk) begin
        check("state",       {30'd0, bus.global_state}, r.st);
        check("cycle",       {27'd0, bus.cycle}, r.cyc);
        check("tile_idx",    {24'd0, bus.tile_idx}, r.tile);
        check("busy",        {31'd0, bus.busy}, (r.st != 0) ? 1 : 0);
        check("load_en",     {31'd0, bus.load_en}, (r.st == 1) ? 1 : 0);
        check("mac_en",      {31'd0, bus.mac_en}, (r.st == 2) ? 1 : 0);
        check("store_valid", {31'd0, bus.store_valid}, (r.st == 3) ? 1 : 0);
        check("done",        {31'd0, bus.done}, r.dn);
        check("aborted",     {31'd0, bus.aborted}, r.ab);
      end
      rst             = r.rs;
      bus.start       = r.start;
      bus.num_tiles   = TW'(r.n);
      bus.abort       = r.abort;
      bus.store_ready = r.ready;
    end
  endtask

  initial begin
    rec_t r0;
    rst = 1'b1;
    bus.start = 1'b0; bus.num_tiles = '0; bus.abort = 1'b0; bus.store_ready = 1'b1;
    // Hold rst for a first, unchecked cycle, then check the reset state.
    r0.chk = 1'b0; r0.st = 0; r0.cyc = 0; r0.tile = 0; r0.dn = 0; r0.ab = 0;
    r0.start = 1'b0; r0.n = 0; r0.abort = 1'b0; r0.ready = 1'b1; r0.rs = 1'b1;
    sb_q.push_back(r0);
    push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    drain();

    job(1, -1, -1, 0, 1'b0, -1);          // single tile, ready held high
    job(3, -1, -1, 0, 1'b0, -1);          // three tiles back to back
    job(1,  0, -1, 0, 1'b0, -1);          // 3-clock stall at cycle 7
    job(3, -1,  1, 4, 1'b0, -1);          // abort at MAC cycle 4 of tile 1
    job(2, -1,  1, 8, 1'b0, -1);          // abort on the last store beat
    job(2, -1, -1, 0, 1'b0,  0);          // start while busy is ignored
    job(2, -1,  0, 7, 1'b1, -1);          // rst at STORE cycle 7
    drain();

    // start with num_tiles=0: done next clock, busy never rises
    push(0, 0, 0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    push(0, 0, 0, 1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    // abort in IDLE suppresses start
    push(0, 0, 0, 0, 0, 1'b1, 2, 1'b1, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    push(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    drain();
    job(1, -1, -1, 0, 1'b0, -1);          // normal job after the IDLE cases
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
